alu_op_sequencer: RTL
=====================

# alu_op_sequencer

Control sequencer that drives the one-hot operation selects of the 8-bit ALU result multiplexer. It accepts one instruction byte per transaction over a valid/ready handshake and decodes the opcode into exactly one of the six select lines (and, or, not, xor, sum, reg). It then steps a fixed execute/writeback schedule, issuing register-file read addresses, the writeback strobe and a completion pulse. The block sits between the instruction source and the datapath: its select outputs feed the result mux directly, and its address and strobe outputs feed the register file.

## Interface
Parameters: none; all widths are fixed.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- instr_valid  input  1  instruction byte on `instr` is offered.
- instr  input  8  fields: [7:5] opcode, [3:2] destination register, [1:0] source register; bit 4 is reserved and ignored.
- instr_ready  output  1  sequencer can accept an instruction.
- aop  output  1  select AND result.
- bop  output  1  select OR result.
- cop  output  1  select NOT result.
- dop  output  1  select XOR result.
- eop  output  1  select SUM result.
- fop  output  1  select REG (move) result.
- src_a  output  2  register-file read address A; equals the destination field.
- src_b  output  2  register-file read address B; equals the source field.
- wb_addr  output  2  writeback register address.
- reg_we  output  1  register-file write enable.
- done  output  1  one-cycle pulse when an instruction retires.
- illegal  output  1  one-cycle pulse when a reserved opcode is rejected.
- retired_cnt  output  8  count of retired instructions.

## Operation
- States: IDLE, DECODE, EXEC, EXEC2, WB.
- Handshake:
  - instr_ready = 1 only in IDLE.
  - An instruction is accepted on a rising edge where instr_valid & instr_ready. The full instr byte is latched into an internal register on that edge.
  - instr_valid while not ready is ignored. There is no buffering, and the source must hold its byte.
- Opcode map: 0→aop, 1→bop, 2→cop, 3→dop, 4→eop, 5→fop. Opcodes 6 and 7 are illegal.
- Transitions:
  - IDLE→DECODE on accept.
  - DECODE→IDLE if the opcode is illegal. illegal=1 during this DECODE cycle; no select, no reg_we, no count.
  - DECODE→EXEC if the opcode is legal.
  - EXEC→EXEC2 if the opcode is 4 (sum). EXEC2 is an extra settle cycle for the carry chain.
  - EXEC→WB for every other legal opcode.
  - EXEC2→WB unconditionally.
  - WB→IDLE unconditionally.
- Select outputs:
  - Exactly one select is high in EXEC, EXEC2 and WB, and it is held constant across those states.
  - All six selects are 0 in IDLE and DECODE.
  - The selects are registered outputs (no decode glitches).
- Addresses: src_a, src_b and wb_addr are driven from the latched byte from DECODE through WB; they are 0 in IDLE.
- WB cycle: reg_we=1 and done=1 for exactly one cycle, and retired_cnt increments by 1. The count wraps 255→0 with no flag.
- NOT (opcode 2) still drives src_b; the datapath ignores it.
- Reset values: instr_ready=1 after reset release; every other output 0, including retired_cnt=0; state=IDLE.
- Asserting reset mid-transaction immediately clears the state, outputs and latched instruction. An interrupted instruction neither retires nor writes.

## Timing
- Accept edge = cycle 0.
- Non-sum opcode:
  - DECODE in cycle 1, EXEC in cycle 2, WB in cycle 3 (reg_we, done).
  - instr_ready high again in cycle 4.
  - Throughput: 1 instruction per 4 cycles.
- Sum opcode: WB in cycle 4, ready in cycle 5 (5 cycles per instruction).
- Illegal opcode: illegal pulse in cycle 1, ready in cycle 2.
- The select becomes valid one cycle before reg_we, so the mux output is stable for at least one full cycle before the write edge.
- Back-to-back: with instr_valid held high, the next accept occurs on the first edge where the state is IDLE.

## Test plan
- Reset: assert rst_n=0 mid-EXEC of opcode 1 → all selects, reg_we and done go 0 immediately; retired_cnt=0; instr_ready=1 after release; no writeback ever occurs.
- AND retire: instr=0x0D (op0, dst3, src1) accepted at cycle 0 → aop=1 in cycles 2–3; src_a=3, src_b=1, wb_addr=3; reg_we=done=1 only in cycle 3; retired_cnt=1.
- Sum timing: instr=0x86 (op4, dst1, src2) → eop=1 in cycles 2–4; reg_we only in cycle 4; instr_ready low in cycles 1–4.
- Illegal: instr=0xE0 (op7) → illegal=1 in cycle 1 only; no select or reg_we asserted; retired_cnt unchanged; ready in cycle 2. Repeat with op6 and expect identical behaviour.
- Back-to-back and ignored valid: hold instr_valid=1 while cycling through opcodes 0–5 → each byte is accepted only when ready; exactly one select is high at any time; a byte changed while busy is never latched.
- Wrap: retire 256 legal instructions → retired_cnt returns to 0; done pulses exactly 256 times.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - one-hot ALU result-select sequencer with execute/writeback schedule
module alu_op_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [7:0] instr,
    output logic       instr_ready,
    output logic       aop,
    output logic       bop,
    output logic       cop,
    output logic       dop,
    output logic       eop,
    output logic       fop,
    output logic [1:0] src_a,
    output logic [1:0] src_b,
    output logic [1:0] wb_addr,
    output logic       reg_we,
    output logic       done,
    output logic       illegal,
    output logic [7:0] retired_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        EXEC2  = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] instr_q;
    logic [5:0] sel_q;
    logic [5:0] sel_d;
    logic [2:0] opcode;
    logic       op_legal;
    logic       accept;
    logic       busy;
    logic       unused_rsvd;

    assign opcode      = instr_q[7:5];
    assign op_legal    = (opcode <= 3'd5);
    assign accept      = instr_valid && (state == IDLE);
    assign busy        = (state != IDLE);
    assign unused_rsvd = instr_q[4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            instr_q     <= 8'd0;
            sel_q       <= 6'd0;
            retired_cnt <= 8'd0;
        end else begin
            state <= next_state;
            sel_q <= sel_d;
            if (accept) begin
                instr_q <= instr;
            end
            if (state == WB) begin
                retired_cnt <= retired_cnt + 8'd1;
            end
        end
    end

    // Selects are computed from the next state so they are registered and
    // already stable when EXEC begins, one full cycle ahead of the write.
    always_comb begin
        next_state = state;
        sel_d      = 6'd0;
        case (state)
            IDLE:    if (accept) next_state = DECODE;
            DECODE:  next_state = op_legal ? EXEC : IDLE;
            EXEC:    next_state = (opcode == 3'd4) ? EXEC2 : WB;
            EXEC2:   next_state = WB;
            WB:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if ((next_state == EXEC) || (next_state == EXEC2) || (next_state == WB)) begin
            sel_d = 6'b000001 << opcode;
        end
    end

    assign instr_ready = (state == IDLE);
    assign {fop, eop, dop, cop, bop, aop} = sel_q;
    assign src_a   = busy ? instr_q[3:2] : 2'd0;
    assign wb_addr = busy ? instr_q[3:2] : 2'd0;
    assign src_b   = busy ? instr_q[1:0] : 2'd0;
    assign reg_we  = (state == WB);
    assign done    = (state == WB);
    assign illegal = (state == DECODE) && !op_legal;

endmodule
